// File: rtl/control_pkg.sv
// Shared control-unit definitions: sequencer states, instruction ID constants
// and the ID lists used by the classifier.
package control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH      = 4'd0,
    ST_DECODE     = 4'd1,
    ST_EXECUTE    = 4'd2,
    ST_WRITEBACK  = 4'd3,
    ST_MEM_RD     = 4'd4,
    ST_MEM_WR     = 4'd5,
    ST_BRANCH     = 4'd6,
    ST_JUMP       = 4'd7,
    ST_SWI        = 4'd8,
    ST_PAUSE      = 4'd9,
    ST_INPUT_WAIT = 4'd10,
    ST_HALT       = 4'd11,
    ST_TRAP       = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_SWI,
    CLS_SYS,
    CLS_INVALID
  } id_class_t;

  localparam logic [6:0] ID_BX     = 7'h26;
  localparam logic [6:0] ID_OUTPUT = 7'h45;
  localparam logic [6:0] ID_PAUSE  = 7'h46;
  localparam logic [6:0] ID_INPUT  = 7'h47;
  localparam logic [6:0] ID_SWI    = 7'h48;
  localparam logic [6:0] ID_B      = 7'h49;
  localparam logic [6:0] ID_NOP    = 7'h4A;
  localparam logic [6:0] ID_HLT    = 7'h4B;
  localparam logic [6:0] ID_BXPC   = 7'h4C;
  localparam logic [6:0] ID_RESET  = 7'h64;

  function automatic logic is_load(input logic [6:0] id);
    return id inside {7'h31, 7'h33, 7'h35, 7'h37};
  endfunction

  function automatic logic is_store(input logic [6:0] id);
    return id inside {7'h30, 7'h32, 7'h34, 7'h36};
  endfunction

  // Compare/test instructions only update flags.
  function automatic logic is_nowb(input logic [6:0] id);
    return id inside {7'h14, 7'h15, 7'h16, 7'h17, 7'h1F};
  endfunction

endpackage

// File: rtl/id_classifier.sv
// Combinational instruction-ID classifier, shared by the sequencer, hazard
// and debug logic.
module id_classifier
  import control_pkg::*;
(
  input  logic [6:0] id,
  output id_class_t  id_class,
  output logic       nowb
);

  always_comb begin
    id_class = CLS_INVALID;
    if ((id >= 7'h01 && id <= 7'h25) || (id >= 7'h28 && id <= 7'h2F) ||
        (id >= 7'h38 && id <= 7'h44))
      id_class = CLS_ALU;
    else if (is_load(id))
      id_class = CLS_LOAD;
    else if (is_store(id))
      id_class = CLS_STORE;
    else if (id == ID_BX || id == ID_B || id == ID_BXPC)
      id_class = CLS_BRANCH;
    else if (id == ID_SWI)
      id_class = CLS_SWI;
    else if (id inside {ID_OUTPUT, ID_NOP, ID_PAUSE, ID_INPUT, ID_HLT, ID_RESET})
      id_class = CLS_SYS;
    nowb = is_nowb(id);
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 16-bit
// core; drives one-cycle datapath strobes from the decoded instruction ID.
module instruction_sequencer
  import control_pkg::*;
#(
  parameter int ID_WIDTH    = 7,
  parameter int STATE_WIDTH = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ID_WIDTH-1:0]    ID,
  input  logic                   condition_met,
  input  logic                   mem_ready,
  input  logic                   continue_button,
  input  logic                   input_valid,
  output logic                   ir_load,
  output logic                   pc_increment,
  output logic                   pc_load,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   inst_fetch,
  output logic                   reg_write,
  output logic                   lr_write,
  output logic                   halted,
  output logic                   waiting,
  output logic                   trap,
  output logic [STATE_WIDTH-1:0] state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT);

  state_t            state_q, state_d;
  id_class_t         id_class, cls_q;
  logic              nowb, nowb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout;

  id_classifier u_id_classifier (
    .id       (ID),
    .id_class (id_class),
    .nowb     (nowb)
  );

  // Cycle count within the current memory-wait state; clears on every entry.
  assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      cls_q   <= CLS_ALU;
      nowb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR})
        cnt_q <= cnt_q + 1'b1;
      if (state_q == ST_DECODE) begin
        cls_q  <= id_class;
        nowb_q <= nowb;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_load      = 1'b0;
    pc_increment = 1'b0;
    pc_load      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    inst_fetch   = 1'b0;
    reg_write    = 1'b0;
    lr_write     = 1'b0;
    halted       = 1'b0;
    waiting      = 1'b0;
    trap         = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read     = 1'b1;
        inst_fetch   = 1'b1;
        ir_load      = mem_ready;
        pc_increment = mem_ready;
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) state_d = ST_TRAP;
      end
      ST_DECODE: begin
        case (id_class)
          CLS_ALU, CLS_LOAD, CLS_STORE: state_d = ST_EXECUTE;
          CLS_BRANCH: state_d = (ID == ID_BXPC) ? ST_JUMP : ST_BRANCH;
          CLS_SWI:    state_d = ST_SWI;
          CLS_SYS: begin
            case (ID)
              ID_PAUSE: state_d = ST_PAUSE;
              ID_INPUT: state_d = ST_INPUT_WAIT;
              ID_HLT:   state_d = ST_HALT;
              ID_RESET: state_d = ST_JUMP;
              default:  state_d = ST_FETCH;
            endcase
          end
          default: state_d = ST_TRAP;
        endcase
      end
      // Loads and stores spend the execute cycle forming the address.
      ST_EXECUTE: begin
        if (cls_q == CLS_LOAD)       state_d = ST_MEM_RD;
        else if (cls_q == CLS_STORE) state_d = ST_MEM_WR;
        else                         state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        reg_write = !nowb_q;
        state_d   = ST_FETCH;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready)    state_d = ST_WRITEBACK;
        else if (timeout) state_d = ST_TRAP;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        if (mem_ready)    state_d = ST_FETCH;
        else if (timeout) state_d = ST_TRAP;
      end
      ST_BRANCH: begin
        pc_load = condition_met;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        pc_load = 1'b1;
        state_d = ST_FETCH;
      end
      ST_SWI: begin
        lr_write = 1'b1;
        state_d  = ST_JUMP;
      end
      ST_PAUSE: begin
        waiting = 1'b1;
        if (continue_button) state_d = ST_FETCH;
      end
      ST_INPUT_WAIT: begin
        waiting = 1'b1;
        if (input_valid) state_d = ST_WRITEBACK;
      end
      ST_HALT: halted = 1'b1;
      ST_TRAP: begin
        trap    = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_FETCH;
    endcase

    // Reset overrides everything, including a request in flight.
    if (reset) begin
      ir_load      = 1'b0;
      pc_increment = 1'b0;
      pc_load      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      inst_fetch   = 1'b0;
      reg_write    = 1'b0;
      lr_write     = 1'b0;
      halted       = 1'b0;
      waiting      = 1'b0;
      trap         = 1'b0;
    end
  end

  assign state = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with hand-computed expectations.
module tb_instruction_sequencer;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_EXEC  = 4'd2,
                         S_WB    = 4'd3,  S_MRD    = 4'd4, S_MWR   = 4'd5,
                         S_BR    = 4'd6,  S_JMP    = 4'd7, S_SWI   = 4'd8,
                         S_PAUSE = 4'd9,  S_INW    = 4'd10, S_HALT = 4'd11,
                         S_TRAP  = 4'd12;

  logic       clock, reset;
  logic [6:0] id;
  logic       condition_met, mem_ready, continue_button, input_valid;
  logic       ir_load, pc_increment, pc_load, mem_read, mem_write, inst_fetch;
  logic       reg_write, lr_write, halted, waiting, trap;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  instruction_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .ID              (id),
    .condition_met   (condition_met),
    .mem_ready       (mem_ready),
    .continue_button (continue_button),
    .input_valid     (input_valid),
    .ir_load         (ir_load),
    .pc_increment    (pc_increment),
    .pc_load         (pc_load),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .inst_fetch      (inst_fetch),
    .reg_write       (reg_write),
    .lr_write        (lr_write),
    .halted          (halted),
    .waiting         (waiting),
    .trap            (trap),
    .state           (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; id = 7'h04; condition_met = 1'b0; mem_ready = 1'b1;
    continue_button = 1'b0; input_valid = 1'b0;
    step(); step();
    chk("rst_state", state, S_FETCH);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_ir_load", ir_load, 0);
    chk("rst_halted", halted, 0);
    chk("rst_waiting", waiting, 0);
    chk("rst_trap", trap, 0);
    reset = 1'b0; #1;

    // ADD: FETCH, DECODE, EXECUTE, WRITEBACK
    chk("add_c1_state", state, S_FETCH);
    chk("add_c1_ir_load", ir_load, 1);
    chk("add_c1_pc_inc", pc_increment, 1);
    chk("add_c1_inst_fetch", inst_fetch, 1);
    step(); chk("add_c2_state", state, S_DECODE); chk("add_c2_ir_load", ir_load, 0);
    chk("add_c2_reg_write", reg_write, 0);
    step(); chk("add_c3_state", state, S_EXEC); chk("add_c3_reg_write", reg_write, 0);
    step(); chk("add_c4_state", state, S_WB); chk("add_c4_reg_write", reg_write, 1);
    step(); chk("add_c5_state", state, S_FETCH); chk("add_c5_reg_write", reg_write, 0);

    // Compare: no register write
    id = 7'h14;
    step(); step(); step();
    chk("cmp_wb_state", state, S_WB);
    chk("cmp_wb_reg_write", reg_write, 0);
    step(); chk("cmp_back_fetch", state, S_FETCH);

    // Load with three wait cycles in MEM_RD
    id = 7'h31;
    step(); step(); chk("ld_exec", state, S_EXEC);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_state", state, S_MRD);
      chk("ld_wait_mem_read", mem_read, 1);
      chk("ld_wait_reg_write", reg_write, 0);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("ld_ready_state", state, S_MRD);
    chk("ld_ready_mem_read", mem_read, 1);
    step(); chk("ld_wb_state", state, S_WB);
    chk("ld_wb_reg_write", reg_write, 1); chk("ld_wb_trap", trap, 0);
    step(); chk("ld_back_fetch", state, S_FETCH);

    // Branch not taken, then taken
    id = 7'h49; condition_met = 1'b0;
    step(); step(); chk("bnt_state", state, S_BR); chk("bnt_pc_load", pc_load, 0);
    step(); chk("bnt_back_fetch", state, S_FETCH);
    condition_met = 1'b1;
    step(); step(); chk("bt_state", state, S_BR); chk("bt_pc_load", pc_load, 1);
    step(); chk("bt_back_fetch", state, S_FETCH);

    // BX to PC: unconditional
    id = 7'h4C; condition_met = 1'b0;
    step(); step(); chk("bxpc_pc_load", pc_load, 1);
    step(); chk("bxpc_back_fetch", state, S_FETCH);

    // SWI: link write, then PC load
    id = 7'h48;
    step(); step(); chk("swi_state", state, S_SWI);
    chk("swi_lr_write", lr_write, 1); chk("swi_c3_pc_load", pc_load, 0);
    step(); chk("swi_c4_lr_write", lr_write, 0); chk("swi_c4_pc_load", pc_load, 1);
    step(); chk("swi_back_fetch", state, S_FETCH);

    // INPUT
    id = 7'h47;
    step(); step(); chk("in_state", state, S_INW); chk("in_waiting", waiting, 1);
    step(); chk("in_still_wait", state, S_INW);
    input_valid = 1'b1;
    step(); chk("in_wb_reg_write", reg_write, 1); chk("in_wb_waiting", waiting, 0);
    input_valid = 1'b0;
    step(); chk("in_back_fetch", state, S_FETCH);

    // PAUSE: ten waiting cycles, continue on the tenth
    id = 7'h46;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) continue_button = 1'b1;
      #1;
      chk("pause_waiting", waiting, 1);
      chk("pause_state", state, S_PAUSE);
      step();
    end
    continue_button = 1'b0;
    chk("pause_back_fetch", state, S_FETCH); chk("pause_waiting_off", waiting, 0);

    // NOP returns straight to fetch
    id = 7'h4A;
    step(); step(); chk("nop_fetch", state, S_FETCH); chk("nop_reg_write", reg_write, 0);

    // Reset-state instruction: PC load to zero
    id = 7'h64;
    step(); step(); chk("rsti_state", state, S_JMP); chk("rsti_pc_load", pc_load, 1);
    step(); chk("rsti_back_fetch", state, S_FETCH);

    // Store, reset asserted mid-access
    id = 7'h30;
    step(); step();
    mem_ready = 1'b0;
    step(); chk("st_state", state, S_MWR); chk("st_mem_write", mem_write, 1);
    step(); chk("st_hold", state, S_MWR);
    reset = 1'b1; #1;
    chk("st_rst_mem_write", mem_write, 0);
    step(); reset = 1'b0; #1;
    chk("st_rst_state", state, S_FETCH); chk("st_rst_mem_write2", mem_write, 0);
    mem_ready = 1'b1; #1;

    // Invalid ID 0x7F: trap then halt
    id = 7'h7F;
    step(); step(); chk("inv_state", state, S_TRAP); chk("inv_trap", trap, 1);
    step(); chk("inv_trap_off", trap, 0);
    for (int i = 0; i < 50; i++) begin
      chk("inv_halted", halted, 1);
      step();
    end
    do_reset();
    chk("inv_rst_state", state, S_FETCH); chk("inv_rst_halted", halted, 0);

    // Gap ID 0x27 is invalid
    id = 7'h27;
    step(); step(); chk("gap_state", state, S_TRAP);
    do_reset();

    // Fetch timeout
    mem_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      chk("to_fetch_state", state, S_FETCH);
      chk("to_fetch_trap", trap, 0);
      step();
    end
    chk("to_trap_state", state, S_TRAP); chk("to_trap", trap, 1);
    step(); chk("to_halt_state", state, S_HALT); chk("to_halted", halted, 1);

    // mem_ready on the limit cycle completes the fetch
    id = 7'h04;
    do_reset();
    for (int i = 1; i <= 14; i++) step();
    chk("lim_state", state, S_FETCH);
    mem_ready = 1'b1; #1;
    chk("lim_ir_load", ir_load, 1);
    step(); chk("lim_decode", state, S_DECODE); chk("lim_trap", trap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
